illness_update_scheduler: RTL and testbench

Time-multiplexed scheduler that shares the single illness level resource among several update requesters (stimuli, action, neurotransmitter and recovery logic). It decides which requester may update the 9-bit illness resource on each update tick. It drives the resource's inc/dec/fast/setval command pulses. After a setval it imposes a lock-out so the level settles before further updates are accepted.

---
 rtl/illness_update_scheduler.sv | 167 ++++++++++++++++
 tb/tb_illness_update_scheduler.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/illness_update_scheduler.sv
// Tick-paced arbiter that shares the illness level resource among NREQ requesters and
// issues registered inc/dec/fast/setval pulses, with a post-setval settle lock-out.
module illness_update_scheduler #(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned TICK_DIV   = 16,
  parameter int unsigned HOLD_TICKS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [2*NREQ-1:0] op,
  input  logic [NREQ-1:0]   fast_req,
  input  logic              freeze,
  output logic [NREQ-1:0]   gnt,
  output logic              inc,
  output logic              dec,
  output logic              fast,
  output logic              setval,
  output logic              hold
);

  localparam int unsigned CW = $clog2(TICK_DIV);
  localparam int unsigned PW = $clog2(NREQ);

  localparam logic [1:0] OpInc    = 2'b00;
  localparam logic [1:0] OpDec    = 2'b01;
  localparam logic [1:0] OpSetval = 2'b10;

  typedef enum logic [0:0] {StRun, StHold} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [3:0]      hold_cnt_q, hold_cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            inc_q, inc_d;
  logic            dec_q, dec_d;
  logic            fast_q, fast_d;
  logic            setval_q, setval_d;
  logic            hold_q, hold_d;

  logic            tick;
  logic            found;
  logic            sv_hit;
  logic [PW-1:0]   win;
  logic [PW-1:0]   cand;
  logic [1:0]      win_op;
  logic            win_fast;
  int unsigned     idx;

  assign tick = (cnt_q == CW'(TICK_DIV - 1));

  // Setval requests override round-robin; otherwise search upward from the pointer.
  always_comb begin
    found  = 1'b0;
    sv_hit = 1'b0;
    win    = '0;
    cand   = '0;
    idx    = 0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i] && (op[2*i +: 2] == OpSetval)) begin
        found  = 1'b1;
        sv_hit = 1'b1;
        win    = PW'(i);
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      idx  = (int'(ptr_q) + k) % NREQ;
      cand = PW'(idx);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    win_op   = op[{win, 1'b0} +: 2];
    win_fast = fast_req[win];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = tick ? '0 : cnt_q + CW'(1);
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    gnt_d      = '0;
    inc_d      = 1'b0;
    dec_d      = 1'b0;
    fast_d     = 1'b0;
    setval_d   = 1'b0;
    hold_d     = hold_q;
    if (tick) begin
      unique case (state_q)
        StRun: begin
          if (!freeze && (req != '0)) begin
            gnt_d[win] = 1'b1;
            if (!sv_hit) begin
              ptr_d = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
            end
            case (win_op)
              OpInc: begin
                inc_d  = 1'b1;
                fast_d = win_fast;
              end
              OpDec: begin
                dec_d  = 1'b1;
                fast_d = win_fast;
              end
              OpSetval: begin
                setval_d = 1'b1;
                if (HOLD_TICKS > 0) begin
                  state_d    = StHold;
                  hold_cnt_d = 4'(HOLD_TICKS);
                  hold_d     = 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
        StHold: begin
          // Freeze does not pause the settle countdown.
          if (hold_cnt_q == 4'd1) begin
            state_d    = StRun;
            hold_cnt_d = '0;
            hold_d     = 1'b0;
          end else begin
            hold_cnt_d = hold_cnt_q - 4'd1;
          end
        end
        default: state_d = StRun;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StRun;
      cnt_q      <= '0;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      gnt_q      <= '0;
      inc_q      <= 1'b0;
      dec_q      <= 1'b0;
      fast_q     <= 1'b0;
      setval_q   <= 1'b0;
      hold_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_q      <= gnt_d;
      inc_q      <= inc_d;
      dec_q      <= dec_d;
      fast_q     <= fast_d;
      setval_q   <= setval_d;
      hold_q     <= hold_d;
    end
  end

  assign gnt    = gnt_q;
  assign inc    = inc_q;
  assign dec    = dec_q;
  assign fast   = fast_q;
  assign setval = setval_q;
  assign hold   = hold_q;

endmodule

// File: tb/tb_illness_update_scheduler.sv
// Directed bench for illness_update_scheduler: integer-level reference model compared every
// cycle, plus literal expectations at the key cycles of each scenario.
module tb_illness_update_scheduler;

  localparam int N  = 4;
  localparam int TD = 4;
  localparam int HT = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic [2*N-1:0] op;
  logic [N-1:0] fast_req;
  logic         freeze;
  logic [N-1:0] gnt;
  logic         inc, dec, fast, setval, hold;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  illness_update_scheduler #(
    .NREQ(N), .TICK_DIV(TD), .HOLD_TICKS(HT)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .fast_req(fast_req), .freeze(freeze),
    .gnt(gnt), .inc(inc), .dec(dec), .fast(fast), .setval(setval), .hold(hold)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Reference model: cycle count, pointer and remaining skipped ticks as plain integers.
  int m_cnt, m_ptr, m_hold_left;
  int e_gnt, e_inc, e_dec, e_fast, e_setval, e_hold;

  always @(posedge clk) begin
    int w, o;
    bit t;
    if (rst) begin
      m_cnt = 0; m_ptr = 0; m_hold_left = 0;
      e_gnt = 0; e_inc = 0; e_dec = 0; e_fast = 0; e_setval = 0; e_hold = 0;
    end else begin
      t = (m_cnt == TD - 1);
      m_cnt = (m_cnt + 1) % TD;
      e_gnt = 0; e_inc = 0; e_dec = 0; e_fast = 0; e_setval = 0;
      if (t) begin
        if (m_hold_left > 0) begin
          m_hold_left--;
          if (m_hold_left == 0) e_hold = 0;
        end else if (!freeze && req != 0) begin
          w = -1;
          for (int i = 0; i < N; i++)
            if (w < 0 && req[i] && ((op >> (2 * i)) & 3) == 2) w = i;
          if (w < 0) begin
            for (int k = 0; k < N; k++)
              if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            m_ptr = (w + 1) % N;
          end
          e_gnt = 1 << w;
          o = (op >> (2 * w)) & 3;
          if (o == 0) begin e_inc = 1; e_fast = fast_req[w]; end
          if (o == 1) begin e_dec = 1; e_fast = fast_req[w]; end
          if (o == 2) begin
            e_setval = 1;
            if (HT > 0) begin m_hold_left = HT; e_hold = 1; end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_gnt", int'(gnt), e_gnt);
      chk("m_inc", int'(inc), e_inc);
      chk("m_dec", int'(dec), e_dec);
      chk("m_fast", int'(fast), e_fast);
      chk("m_setval", int'(setval), e_setval);
      chk("m_hold", int'(hold), e_hold);
    end
  end

  task automatic wait_gnt(input int exp, input string nm);
    for (int i = 0; i < 3 * TD; i++) begin
      @(negedge clk);
      if (gnt != 0) break;
    end
    chk(nm, int'(gnt), exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = '0; op = '1; fast_req = '0; freeze = 1'b0;
    @(negedge clk);
    cmp_en = 1'b1;
    @(negedge clk);
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_hold", int'(hold), 0);

    // First tick lands in cycle TD-1, grant visible in cycle TD.
    rst = 1'b0; req = 4'b0001; op = 8'hFC;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      chk("first_gnt", int'(gnt), (n == 4) ? 1 : 0);
      chk("first_inc", int'(inc), (n == 4) ? 1 : 0);
      if (n == 4) req = '0;
    end

    // Round-robin with all requesters held.
    do_reset();
    req = 4'b1111; op = 8'h00;
    wait_gnt(1, "rr0"); chk("rr0_inc", int'(inc), 1);
    wait_gnt(2, "rr1"); chk("rr1_inc", int'(inc), 1);
    wait_gnt(4, "rr2"); chk("rr2_inc", int'(inc), 1);
    wait_gnt(8, "rr3"); chk("rr3_inc", int'(inc), 1);
    wait_gnt(1, "rr4"); chk("rr4_inc", int'(inc), 1);
    req = '0;

    // Setval override and HOLD lock-out with pointer at 1.
    do_reset();
    req = 4'b0001; op = 8'hFC;
    wait_gnt(1, "pre_sv");
    req = 4'b0110; op = 8'hE3;
    wait_gnt(4, "sv_gnt");
    chk("sv_setval", int'(setval), 1);
    chk("sv_hold", int'(hold), 1);
    chk("sv_fast", int'(fast), 0);
    req = 4'b0010;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      chk("hold_gnt", int'(gnt), (j == 12) ? 2 : 0);
      chk("hold_flag", int'(hold), (j < 8) ? 1 : 0);
      if (j == 12) begin
        chk("post_hold_inc", int'(inc), 1);
        req = '0;
      end
    end

    // Fast decrement from requester 3.
    req = 4'b1000; op = 8'h7F; fast_req = 4'b1000;
    wait_gnt(8, "dec_gnt");
    chk("dec_dec", int'(dec), 1);
    chk("dec_fast", int'(fast), 1);
    chk("dec_inc", int'(inc), 0);
    chk("dec_setval", int'(setval), 0);
    req = '0; fast_req = '0;
    @(negedge clk);
    chk("dec_pulse_end", int'(dec), 0);

    // Freeze across three ticks, then release.
    freeze = 1'b1; req = 4'b0001; op = 8'hFC;
    for (int j = 0; j < 3 * TD; j++) begin
      @(negedge clk);
      chk("freeze_gnt", int'(gnt), 0);
    end
    freeze = 1'b0;
    wait_gnt(1, "unfreeze_gnt");
    req = '0;

    // Reset in the middle of HOLD; pointer must come back to 0.
    req = 4'b0001; op = 8'hFE;
    wait_gnt(1, "sv2_gnt");
    chk("sv2_hold", int'(hold), 1);
    req = '0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_hold_clr", int'(hold), 0);
    chk("rst_gnt_clr", int'(gnt), 0);
    rst = 1'b0; req = 4'b0011; op = 8'hF0;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      chk("post_rst_gnt", int'(gnt), (n == 4) ? 1 : 0);
    end
    req = '0;
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
